spio_spinnaker_link_sync_to_async_fifo: RTL and testbench

Transmit-side counterpart of the link receiver. Buffers RTZ 2-of-7 flits from the synchronous packet serializer (vld/rdy) and drives them onto the asynchronous SpiNNaker link as NRZ 2-of-7 transitions, one flit per SL_ACK_IN transition. Sits between the packet serializer and the SpiNNaker link pins. Fully synchronous to CLK_IN; SL_ACK_IN is the only asynchronous input.

---
 rtl/spio_spinnaker_link_sync_to_async_fifo.sv | 108 ++++++++++
 tb/tb_spio_spinnaker_link_sync_to_async_fifo.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_sync_to_async_fifo.sv
// Buffers RTZ 2-of-7 flits from the packet serializer and drives them onto the
// asynchronous SpiNNaker link as NRZ transitions, one flit per SL_ACK_IN transition.
module spio_spinnaker_link_sync_to_async_fifo #(
    parameter int ADDR_WIDTH  = 2,
    parameter int BUFF_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_IN,
    input  logic       rst,
    input  logic [6:0] flt_data_2of7,
    input  logic       flt_vld,
    output logic       flt_rdy,
    output logic [6:0] SL_DATA_2OF7_OUT,
    input  logic       SL_ACK_IN
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(BUFF_DEPTH);

    state_t                 state, state_nxt;
    logic [6:0]             buffer [BUFF_DEPTH];
    logic [ADDR_WIDTH-1:0]  wrp, rdp;
    logic [ADDR_WIDTH:0]    count;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_ref, ack_ref_nxt;
    logic                   ack_s, ack_evt;
    logic                   push, pop;
    logic [6:0]             head, data_nxt;

    assign flt_rdy = !rst && (count != FULL);
    assign push    = flt_vld && flt_rdy;
    assign head    = buffer[rdp];
    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign ack_evt = (ack_s != ack_ref);

    // Buffer storage carries data only; validity is tracked by count/pointers.
    always_ff @(posedge CLK_IN) begin
        if (push) begin
            buffer[wrp] <= flt_data_2of7;
        end
    end

    always_ff @(posedge CLK_IN or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wrp              <= '0;
            rdp              <= '0;
            count            <= '0;
            ack_sync         <= '0;
            ack_ref          <= 1'b0;
            SL_DATA_2OF7_OUT <= 7'd0;
        end else begin
            state            <= state_nxt;
            ack_sync         <= {ack_sync[SYNC_STAGES-2:0], SL_ACK_IN};
            ack_ref          <= ack_ref_nxt;
            SL_DATA_2OF7_OUT <= data_nxt;
            count            <= count + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
            if (push) begin
                wrp <= wrp + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rdp <= rdp + ADDR_WIDTH'(1);
            end
        end
    end

    // Zero symbols are popped without a link transition so they never wait for an ack.
    always_comb begin
        state_nxt   = state;
        ack_ref_nxt = ack_ref;
        data_nxt    = SL_DATA_2OF7_OUT;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                // Nothing outstanding: any ack transition seen here is absorbed.
                ack_ref_nxt = ack_s;
                if (count != '0) begin
                    pop = 1'b1;
                    if (head != 7'd0) begin
                        data_nxt  = SL_DATA_2OF7_OUT ^ head;
                        state_nxt = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_evt) begin
                    ack_ref_nxt = ack_s;
                    if (count != '0) begin
                        pop = 1'b1;
                        if (head != 7'd0) begin
                            data_nxt = SL_DATA_2OF7_OUT ^ head;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spio_spinnaker_link_sync_to_async_fifo.sv
// Self-checking bench for the sync-to-async link transmitter FIFO.
module tb_spio_spinnaker_link_sync_to_async_fifo;

    logic       CLK_IN = 1'b0;
    logic       rst;
    logic [6:0] flt_data_2of7;
    logic       flt_vld;
    logic       flt_rdy;
    logic [6:0] SL_DATA_2OF7_OUT;
    logic       SL_ACK_IN;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] link_model;

    always #5 CLK_IN = ~CLK_IN;

    spio_spinnaker_link_sync_to_async_fifo #(
        .ADDR_WIDTH (2),
        .BUFF_DEPTH (4),
        .SYNC_STAGES(2)
    ) dut (
        .CLK_IN          (CLK_IN),
        .rst             (rst),
        .flt_data_2of7   (flt_data_2of7),
        .flt_vld         (flt_vld),
        .flt_rdy         (flt_rdy),
        .SL_DATA_2OF7_OUT(SL_DATA_2OF7_OUT),
        .SL_ACK_IN       (SL_ACK_IN)
    );

    function automatic logic [6:0] rand_sym();
        int unsigned a, b;
        logic [6:0]  one;
        one = 7'd1;
        a = $urandom_range(0, 6);
        b = (a + 1 + $urandom_range(0, 5)) % 7;
        return (one << a) | (one << b);
    endfunction

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick(output logic acc);
        acc = flt_vld && flt_rdy;
        @(posedge CLK_IN);
        #1;
        if (acc) flt_vld = 1'b0;
    endtask

    task automatic ticks(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic test_reset();
        logic a;
        repeat (3) @(posedge CLK_IN);
        #1;
        checks++;
        if (SL_DATA_2OF7_OUT !== 7'd0) begin
            errors++; $display("FAIL reset_data got %h exp %h", SL_DATA_2OF7_OUT, 7'd0);
        end
        checks++;
        if (flt_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy got %b exp 0", flt_rdy);
        end
        rst = 1'b0;
        link_model = 7'd0;
        tick(a);
        checks++;
        if (flt_rdy !== 1'b1) begin
            errors++; $display("FAIL release_rdy got %b exp 1", flt_rdy);
        end
        for (int i = 0; i < 5; i++) begin
            tick(a);
            checks++;
            if (SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL idle_static_ack got %h exp %h", SL_DATA_2OF7_OUT, link_model);
            end
        end
    endtask

    task automatic test_single();
        logic a;
        flt_data_2of7 = 7'h03; flt_vld = 1'b1;
        tick(a);
        checks++;
        if (a !== 1'b1) begin
            errors++; $display("FAIL single_accept got %b exp 1", a);
        end
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL single_early got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        tick(a);
        link_model ^= 7'h03;
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL single_emit got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
        flt_data_2of7 = 7'h0C; flt_vld = 1'b1;
        tick(a);
        tick(a);
        link_model ^= 7'h0C;
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL single_second got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
    endtask

    task automatic test_back_pressure();
        logic [6:0] f [6];
        logic       a;
        int         n;
        f = '{7'h03, 7'h05, 7'h09, 7'h11, 7'h21, 7'h41};
        n = 0;
        flt_data_2of7 = f[0]; flt_vld = 1'b1;
        for (int g = 0; g < 20 && flt_rdy; g++) begin
            tick(a);
            if (a) begin
                n++;
                if (n < 6) begin flt_data_2of7 = f[n]; flt_vld = 1'b1; end
            end
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL bp_accepted got %0d exp 5", n);
        end
        link_model ^= f[0];
        for (int i = 0; i < 3; i++) begin
            tick(a);
            if (a) n++;
            checks++;
            if (flt_rdy !== 1'b0 || SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL bp_hold got rdy %b data %h exp rdy 0 data %h",
                                   flt_rdy, SL_DATA_2OF7_OUT, link_model);
            end
        end
        for (int k = 1; k < 6; k++) begin
            SL_ACK_IN = ~SL_ACK_IN;
            tick(a); if (a) n++;
            tick(a); if (a) n++;
            checks++;
            if (SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL bp_early got %h exp %h", SL_DATA_2OF7_OUT, link_model);
            end
            tick(a); if (a) n++;
            link_model ^= f[k];
            checks++;
            if (SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL bp_emit got %h exp %h", SL_DATA_2OF7_OUT, link_model);
            end
            if (k == 1) begin
                checks++;
                if (flt_rdy !== 1'b1) begin
                    errors++; $display("FAIL bp_slot_free got %b exp 1", flt_rdy);
                end
            end
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL bp_total got %0d exp 6", n);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(4);
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL bp_drained got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
    endtask

    task automatic test_ack_pipelining();
        logic [6:0] f [5];
        logic       a;
        int         n;
        for (int i = 0; i < 5; i++) f[i] = rand_sym();
        n = 0;
        flt_data_2of7 = f[0]; flt_vld = 1'b1;
        for (int g = 0; g < 20 && flt_rdy; g++) begin
            tick(a);
            if (a) begin
                n++;
                if (n < 5) begin flt_data_2of7 = f[n]; flt_vld = 1'b1; end
            end
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL pipe_accepted got %0d exp 5", n);
        end
        link_model ^= f[0];
        for (int k = 1; k < 5; k++) begin
            SL_ACK_IN = ~SL_ACK_IN;
            ticks(2);
            checks++;
            if (SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL pipe_early got %h exp %h", SL_DATA_2OF7_OUT, link_model);
            end
            ticks(1);
            link_model ^= f[k];
            checks++;
            if (SL_DATA_2OF7_OUT !== link_model) begin
                errors++; $display("FAIL pipe_emit got %h exp %h", SL_DATA_2OF7_OUT, link_model);
            end
            ticks(1);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
    endtask

    task automatic test_zero_symbol();
        logic a;
        flt_data_2of7 = 7'h00; flt_vld = 1'b1;
        tick(a);
        flt_data_2of7 = 7'h60; flt_vld = 1'b1;
        tick(a);
        checks++;
        if (a !== 1'b1 || SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL zero_no_change got acc %b data %h exp acc 1 data %h",
                               a, SL_DATA_2OF7_OUT, link_model);
        end
        tick(a);
        link_model ^= 7'h60;
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL zero_then_eop got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
        flt_data_2of7 = 7'h0C; flt_vld = 1'b1;
        tick(a);
        tick(a);
        link_model ^= 7'h0C;
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL zero_single_ack got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
    endtask

    task automatic test_reset_mid_op();
        logic [6:0] f [4];
        logic [6:0] g;
        logic       a;
        int         n;
        for (int i = 0; i < 4; i++) f[i] = rand_sym();
        n = 0;
        flt_data_2of7 = f[0]; flt_vld = 1'b1;
        for (int k = 0; k < 20 && n < 4; k++) begin
            tick(a);
            if (a) begin
                n++;
                if (n < 4) begin flt_data_2of7 = f[n]; flt_vld = 1'b1; end
            end
        end
        link_model ^= f[0];
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL midrst_pre got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        rst = 1'b1;
        #1;
        link_model = 7'd0;
        checks++;
        if (SL_DATA_2OF7_OUT !== 7'd0 || flt_rdy !== 1'b0) begin
            errors++; $display("FAIL midrst_clear got data %h rdy %b exp data 00 rdy 0",
                               SL_DATA_2OF7_OUT, flt_rdy);
        end
        ticks(2);
        rst = 1'b0;
        tick(a);
        SL_ACK_IN = ~SL_ACK_IN;
        for (int i = 0; i < 5; i++) begin
            tick(a);
            checks++;
            if (SL_DATA_2OF7_OUT !== 7'd0 || flt_rdy !== 1'b1) begin
                errors++; $display("FAIL midrst_spurious got data %h rdy %b exp data 00 rdy 1",
                                   SL_DATA_2OF7_OUT, flt_rdy);
            end
        end
        g = rand_sym();
        flt_data_2of7 = g; flt_vld = 1'b1;
        tick(a);
        tick(a);
        link_model ^= g;
        checks++;
        if (SL_DATA_2OF7_OUT !== link_model) begin
            errors++; $display("FAIL midrst_resume got %h exp %h", SL_DATA_2OF7_OUT, link_model);
        end
        SL_ACK_IN = ~SL_ACK_IN;
        ticks(3);
    endtask

    // Random traffic: link values expected in order, one ack answers each transition.
    task automatic test_random(input int n_flits);
        logic [6:0] q [$];
        logic [6:0] prev, cur;
        logic       a, acked;
        int         sent, cyc, ack_cnt;
        sent = 0; cyc = 0; ack_cnt = -1; acked = 1'b1;
        prev = link_model;
        while ((sent < n_flits || flt_vld || q.size() != 0 || ack_cnt >= 0) && cyc < 4000) begin
            cyc++;
            if (!flt_vld && sent < n_flits && $urandom_range(0, 3) != 0) begin
                flt_vld = 1'b1;
                flt_data_2of7 = ($urandom_range(0, 4) == 0) ? 7'd0 : rand_sym();
            end
            if (ack_cnt == 0) begin
                SL_ACK_IN = ~SL_ACK_IN; acked = 1'b1; ack_cnt = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
            end
            cur = flt_data_2of7;
            tick(a);
            if (a) begin
                sent++;
                if (cur != 7'd0) begin
                    link_model ^= cur;
                    q.push_back(link_model);
                end
            end
            if (SL_DATA_2OF7_OUT !== prev) begin
                checks++;
                if (q.size() == 0 || SL_DATA_2OF7_OUT !== q[0]) begin
                    errors++; $display("FAIL rand_order got %h exp %h", SL_DATA_2OF7_OUT,
                                       (q.size() != 0) ? q[0] : prev);
                end
                if (q.size() != 0) void'(q.pop_front());
                checks++;
                if (!acked) begin
                    errors++; $display("FAIL rand_outstanding got 2 exp 1");
                end
                acked = 1'b0;
                prev = SL_DATA_2OF7_OUT;
                ack_cnt = $urandom_range(0, 5);
            end
        end
        checks++;
        if (q.size() != 0 || sent != n_flits) begin
            errors++; $display("FAIL rand_timeout got pending %0d sent %0d exp pending 0 sent %0d",
                               q.size(), sent, n_flits);
        end
        ticks(4);
    endtask

    initial begin
        rst = 1'b1;
        flt_vld = 1'b0;
        flt_data_2of7 = 7'd0;
        SL_ACK_IN = 1'b1;
        link_model = 7'd0;
        test_reset();
        test_single();
        test_back_pressure();
        test_ack_pipelining();
        test_zero_symbol();
        test_reset_mid_op();
        test_random(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
